// File: rtl/cpu_pkg.sv
// Shared fuzzycpu datapath constants and types for the register file.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/regfile.sv
// General-purpose register file: 2**ADDR_W x DATA_W, two combinational read
// ports and one synchronous write port. Register 0 always reads as zero.
// A read of the address being written shows the old value until the clock
// edge; forwarding is left to the pipeline.
module regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_write,
  input  logic [DATA_W-1:0] data_write,
  input  logic [ADDR_W-1:0] addr_one,
  input  logic [ADDR_W-1:0] addr_two,
  output logic [DATA_W-1:0] data_one,
  output logic [DATA_W-1:0] data_two
);

  localparam int                NUM  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM];

  // Storage update: synchronous clear has priority over writeback; writes to r0 are dropped.
  // NOTE: the array is cleared on reset because software expects unwritten
  // registers to read 0 after reset; this costs a clear path on every flop,
  // so only do it for storage with that architectural requirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (addr_write != ZERO)) begin
      // NOTE: state is updated with non-blocking assignments so every read
      // of regs in the same time step sees the pre-edge value.
      regs[addr_write] <= data_write;
    end
  end

  // Read muxes: zero latency, r0 forced to zero so it is defined even before reset.
  always_comb begin
    data_one = '0;
    data_two = '0;
    if (addr_one != ZERO) data_one = regs[addr_one];
    if (addr_two != ZERO) data_two = regs[addr_two];
  end

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed testbench for regfile: vector table plus hand-written corner cases.
module tb_regfile;
  import cpu_pkg::*;

  logic      clk;
  logic      rst;
  logic      we;
  reg_addr_t addr_write;
  reg_data_t data_write;
  reg_addr_t addr_one;
  reg_addr_t addr_two;
  reg_data_t data_one;
  reg_data_t data_two;

  int n_checks = 0;
  int n_pass   = 0;

  regfile dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .addr_write (addr_write),
    .data_write (data_write),
    .addr_one   (addr_one),
    .addr_two   (addr_two),
    .data_one   (data_one),
    .data_two   (data_two)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      we;
    reg_addr_t aw;
    reg_data_t dw;
    reg_addr_t a1;
    reg_addr_t a2;
    reg_data_t e1;
    reg_data_t e2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input reg_data_t actual, input reg_data_t expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Drive inputs on the falling edge, then let one rising edge pass and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    we         = 1'b0;
    addr_write = '0;
    data_write = '0;
    addr_one   = '0;
    addr_two   = '0;

    // r0 reads zero even before any reset.
    #1;
    check("r0_before_reset_one", data_one, 32'h0);
    check("r0_before_reset_two", data_two, 32'h0);

    // One-cycle reset, then every address on both ports reads zero.
    @(negedge clk);
    rst = 1'b1;
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      addr_one = reg_addr_t'(i);
      addr_two = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check($sformatf("reset_r%0d_one", i), data_one, 32'h0);
      check($sformatf("reset_r%0d_two", NUM_REGS - 1 - i), data_two, 32'h0);
    end

    // Vector table: applied before an edge, outputs checked just after it.
    //          we    aw     dw              a1     a2     e1              e2
    vecs[0] = '{1'b1, 5'd1,  32'd25,         5'd1,  5'd0,  32'd25,         32'd0};
    vecs[1] = '{1'b1, 5'd2,  32'd35,         5'd1,  5'd2,  32'd25,         32'd35};
    vecs[2] = '{1'b1, 5'd3,  32'd65,         5'd3,  5'd2,  32'd65,         32'd35};
    vecs[3] = '{1'b0, 5'd0,  32'd0,          5'd1,  5'd2,  32'd25,         32'd35};
    vecs[4] = '{1'b0, 5'd0,  32'd0,          5'd3,  5'd4,  32'd65,         32'd0};
    vecs[5] = '{1'b0, 5'd0,  32'd0,          5'd5,  5'd6,  32'd0,          32'd0};
    vecs[6] = '{1'b1, 5'd0,  32'd5,          5'd0,  5'd0,  32'd0,          32'd0};
    vecs[7] = '{1'b0, 5'd7,  32'hDEADBEEF,   5'd7,  5'd7,  32'd0,          32'd0};
    vecs[8] = '{1'b1, 5'd9,  32'h11,         5'd9,  5'd3,  32'h11,         32'd65};
    vecs[9] = '{1'b1, 5'd31, 32'hA5A5A5A5,   5'd31, 5'd9,  32'hA5A5A5A5,   32'h11};

    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      we         = vecs[v].we;
      addr_write = vecs[v].aw;
      data_write = vecs[v].dw;
      addr_one   = vecs[v].a1;
      addr_two   = vecs[v].a2;
      step();
      check($sformatf("vec%0d_one", v), data_one, vecs[v].e1);
      check($sformatf("vec%0d_two", v), data_two, vecs[v].e2);
    end

    // Combinational read: outputs follow address with no clock edge.
    @(negedge clk);
    we       = 1'b0;
    addr_one = 5'd2;
    addr_two = 5'd31;
    #1;
    check("comb_follow_one", data_one, 32'd35);
    check("comb_follow_two", data_two, 32'hA5A5A5A5);

    // Read during write to r9: old value before the edge, new value after.
    addr_one   = 5'd9;
    addr_two   = 5'd9;
    we         = 1'b1;
    addr_write = 5'd9;
    data_write = 32'h22;
    #1;
    check("rdw_before_one", data_one, 32'h11);
    check("rdw_before_two", data_two, 32'h11);
    step();
    check("rdw_after_one", data_one, 32'h22);
    check("rdw_after_two", data_two, 32'h22);

    // Reset wins over a same-cycle write; earlier contents are cleared too.
    @(negedge clk);
    rst        = 1'b1;
    we         = 1'b1;
    addr_write = 5'd31;
    data_write = 32'hFFFFFFFF;
    addr_one   = 5'd31;
    addr_two   = 5'd1;
    #1;
    check("pre_reset_r31", data_one, 32'hA5A5A5A5);
    check("pre_reset_r1", data_two, 32'd25);
    step();
    check("reset_prio_r31", data_one, 32'h0);
    check("reset_prio_r1", data_two, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    we       = 1'b0;
    addr_one = 5'd9;
    addr_two = 5'd3;
    #1;
    check("post_reset_r9", data_one, 32'h0);
    check("post_reset_r3", data_two, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile
